// File: rtl/dual_port_memory.sv
// ---------------------------------------------------------------------------
// dual_port_memory
//   Instruction/data memory shared by the fetch stage (port A) and the
//   execute/mem stage (port B). Port A is read-only. Port B reads or writes
//   with byte enables. After reset a sequential engine writes INIT_VAL into
//   every word. Until that sweep completes, init_done is low and both ports
//   ignore requests.
//
//   Storage is split into DSIZE/8 byte lanes, one dual_port_memory_lane
//   instance per lane. Each lane has one write port and two combinational
//   read ports. The top level holds the init FSM, the address range checks
//   and the optional output register stage.
//
// Parameters
//   DSIZE    data width in bits (multiple of 8)
//   ASIZE    address width in bits
//   DEPTH    number of words (DEPTH <= 2**ASIZE)
//   RD_LAT   0 = combinational read, 1 = registered read
//   INIT_VAL value written to every word by the init sweep
//
// Ports
//   clk, rst                clock and synchronous active-high reset
//   init_done               high once the init sweep has finished
//   a_en/a_addr             port A read request
//   a_rdata/a_valid         port A response
//   b_en/b_wen/b_be         port B request, write select, byte enables
//   b_addr/b_wdata          port B address and write data
//   b_rdata/b_valid         port B response (old word on a write)
// ---------------------------------------------------------------------------

// One byte lane of storage: a single write port and two async read ports.
// The write index and both read indices arrive already range-checked or
// masked by the top level.
module dual_port_memory_lane #(
    parameter int IW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] a_idx,
    input  logic [IW-1:0] b_idx,
    output logic [7:0]    a_byte,
    output logic [7:0]    b_byte
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Reads see the array before any same-edge write, which gives
    // read-first behaviour on an A/B collision.
    assign a_byte = mem[a_idx];
    assign b_byte = mem[b_idx];
endmodule

module dual_port_memory #(
    parameter int               DSIZE    = 32,
    parameter int               ASIZE    = 8,
    parameter int               DEPTH    = 256,
    parameter int               RD_LAT   = 1,
    parameter logic [DSIZE-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_done,
    input  logic               a_en,
    input  logic [ASIZE-1:0]   a_addr,
    output logic [DSIZE-1:0]   a_rdata,
    output logic               a_valid,
    input  logic               b_en,
    input  logic               b_wen,
    input  logic [DSIZE/8-1:0] b_be,
    input  logic [ASIZE-1:0]   b_addr,
    input  logic [DSIZE-1:0]   b_wdata,
    output logic [DSIZE-1:0]   b_rdata,
    output logic               b_valid
);
    localparam int NB = DSIZE / 8;
    // Index width into the storage array; at least one bit for DEPTH=1.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  LAST    = IW'(DEPTH - 1);
    localparam logic [ASIZE:0] DEPTH_W = DEPTH[ASIZE:0];

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   clr_addr, clr_addr_nxt;
    logic            init_we;
    logic            run;

    // ---------------- init sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        init_we      = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = ~rst;
                if (clr_addr == LAST) state_nxt    = ST_RUN;
                else                  clr_addr_nxt = clr_addr + 1'b1;
            end
            // Counter holds in RUN; it only restarts through rst.
            default: ;
        endcase
    end

    assign run       = (state == ST_RUN);
    assign init_done = run;

    // ---------------- address checks and write steering ----------------
    logic a_ok, b_ok, b_wr;
    logic [IW-1:0] w_idx;

    assign a_ok  = {1'b0, a_addr} < DEPTH_W;
    assign b_ok  = {1'b0, b_addr} < DEPTH_W;
    // Out-of-range writes are dropped here so they never reach storage.
    assign b_wr  = run & b_en & b_wen & b_ok;
    assign w_idx = init_we ? clr_addr : b_addr[IW-1:0];

    logic [NB-1:0]      lane_we;
    logic [NB-1:0][7:0] lane_wdata;
    logic [NB-1:0][7:0] a_word, b_word;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_we[i]    = init_we | (b_wr & b_be[i]);
        assign lane_wdata[i] = init_we ? INIT_VAL[8*i +: 8] : b_wdata[8*i +: 8];

        dual_port_memory_lane #(.IW(IW), .DEPTH(DEPTH)) u_lane (
            .clk    (clk),
            .we     (lane_we[i]),
            .waddr  (w_idx),
            .wdata  (lane_wdata[i]),
            .a_idx  (a_addr[IW-1:0]),
            .b_idx  (b_addr[IW-1:0]),
            .a_byte (a_word[i]),
            .b_byte (b_word[i])
        );
    end

    // Out-of-range reads return zero rather than whatever the truncated
    // index happens to hit.
    logic [DSIZE-1:0] a_mem, b_mem;
    assign a_mem = a_ok ? a_word : '0;
    assign b_mem = b_ok ? b_word : '0;

    // ---------------- read output stage ----------------
    if (RD_LAT == 0) begin : g_comb_rd
        assign a_rdata = a_mem;
        assign b_rdata = b_mem;
        assign a_valid = a_en & run;
        assign b_valid = b_en & run;
    end else begin : g_reg_rd
        always_ff @(posedge clk) begin
            if (rst) begin
                a_valid <= 1'b0;
                b_valid <= 1'b0;
                a_rdata <= '0;
                b_rdata <= '0;
            end else begin
                a_valid <= a_en & run;
                b_valid <= b_en & run;
                // Data holds between requests so the fetch stage can stall.
                if (a_en & run) a_rdata <= a_mem;
                if (b_en & run) b_rdata <= b_mem;
            end
        end
    end
endmodule

// File: tb/tb_dual_port_memory.sv
module tb_dual_port_memory;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en, b_wen;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata;

    logic        done1, av1, bv1, done0, av0, bv0;
    logic [31:0] ar1, br1, ar0, br0;

    int total = 0;
    int bad   = 0;

    // Expected responses: 0=A lat1, 1=B lat1, 2=A lat0, 3=B lat0
    logic [31:0] q [4][$];
    string       qn [4] = '{"a_lat1", "b_lat1", "a_lat0", "b_lat0"};

    always #5 clk = ~clk;

    dual_port_memory #(.DSIZE(32), .ASIZE(8), .DEPTH(16), .RD_LAT(1), .INIT_VAL(IV)) u_dut1 (
        .clk(clk), .rst(rst), .init_done(done1),
        .a_en(a_en), .a_addr(a_addr), .a_rdata(ar1), .a_valid(av1),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rdata(br1), .b_valid(bv1)
    );

    dual_port_memory #(.DSIZE(32), .ASIZE(8), .DEPTH(16), .RD_LAT(0), .INIT_VAL(IV)) u_dut0 (
        .clk(clk), .rst(rst), .init_done(done0),
        .a_en(a_en), .a_addr(a_addr), .a_rdata(ar0), .a_valid(av0),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rdata(br0), .b_valid(bv0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input int s, input logic [31:0] act);
        logic [31:0] exp;
        total++;
        if (q[s].size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected valid, data %h, nothing expected", qn[s], act);
        end else begin
            exp = q[s].pop_front();
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", qn[s], act, exp);
            end
        end
    endtask

    // Monitor: sample away from the active edge, pop on every valid.
    always @(negedge clk) begin
        if (av1 === 1'b1) pop_chk(0, ar1);
        if (bv1 === 1'b1) pop_chk(1, br1);
        if (av0 === 1'b1) pop_chk(2, ar0);
        if (bv0 === 1'b1) pop_chk(3, br0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_en = 1'b0; b_en = 1'b0; b_wen = 1'b0;
    endtask

    // Drive one cycle of requests and queue the expected responses.
    task automatic issue(input logic ae, input logic [7:0] aa, input logic [31:0] aexp,
                         input logic be_, input logic bw, input logic [3:0] bbe,
                         input logic [7:0] ba, input logic [31:0] bwd, input logic [31:0] bexp);
        a_en = ae; a_addr = aa;
        b_en = be_; b_wen = bw; b_be = bbe; b_addr = ba; b_wdata = bwd;
        if (ae)  begin q[0].push_back(aexp); q[2].push_back(aexp); end
        if (be_) begin q[1].push_back(bexp); q[3].push_back(bexp); end
        tick;
        idle;
    endtask

    // Count clocks until init_done; valids must stay low during the sweep.
    task automatic wait_init(output int n1, output int n0);
        n1 = 0; n0 = 0;
        for (int c = 1; c <= 100; c++) begin
            tick;
            check("init_a_valid_lat1", {31'b0, av1}, 32'd0);
            check("init_b_valid_lat1", {31'b0, bv1}, 32'd0);
            if (done1 && n1 == 0) n1 = c;
            if (done0 && n0 == 0) n0 = c;
            if (n0 == 0) begin
                check("init_a_valid_lat0", {31'b0, av0}, 32'd0);
                check("init_b_valid_lat0", {31'b0, bv0}, 32'd0);
            end
            if (n1 != 0 || n0 != 0) idle;
            if (n1 != 0 && n0 != 0) break;
        end
    endtask

    logic [31:0] model [16];

    initial begin
        int n1, n0;
        rst = 1'b1; idle; a_addr = '0; b_addr = '0; b_be = '0; b_wdata = '0;
        repeat (3) tick;
        check("rst_init_done_lat1", {31'b0, done1}, 32'd0);
        check("rst_init_done_lat0", {31'b0, done0}, 32'd0);
        check("rst_a_valid", {31'b0, av1}, 32'd0);
        check("rst_b_valid", {31'b0, bv1}, 32'd0);
        check("rst_a_rdata", ar1, 32'd0);
        check("rst_b_rdata", br1, 32'd0);

        rst = 1'b0;
        wait_init(n1, n0);
        check("init_clocks_lat1", n1, 32'd16);
        check("init_clocks_lat0", n0, 32'd16);

        for (int i = 0; i < 16; i++) issue(1, 8'(i), IV, 0, 0, 4'h0, 8'h0, 32'h0, 32'h0);

        // Full write, then read back.
        issue(0, 8'h0, 32'h0, 1, 1, 4'hF, 8'd5, 32'hDEADBEEF, IV);
        issue(1, 8'd5, 32'hDEADBEEF, 0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
        // Partial write of bytes 0 and 2.
        issue(0, 8'h0, 32'h0, 1, 1, 4'b0101, 8'd5, 32'h11223344, 32'hDEADBEEF);
        issue(0, 8'h0, 32'h0, 1, 0, 4'h0, 8'd5, 32'h0, 32'hDE22BE44);
        // Collision: A sees the old word, the new word after the edge.
        issue(1, 8'd7, IV, 1, 1, 4'hF, 8'd7, 32'hCAFEF00D, IV);
        issue(1, 8'd7, 32'hCAFEF00D, 0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
        // Byte enables all clear: no-op write.
        issue(0, 8'h0, 32'h0, 1, 1, 4'h0, 8'd9, 32'hFFFFFFFF, IV);
        // Out-of-range: reads give 0, write dropped.
        issue(1, 8'd20, 32'h0, 1, 1, 4'hF, 8'd20, 32'h12345678, 32'h0);
        issue(0, 8'h0, 32'h0, 1, 0, 4'h0, 8'd20, 32'h0, 32'h0);

        // Combinational port answers in the same cycle as the request.
        a_en = 1'b1; a_addr = 8'd3;
        q[0].push_back(IV); q[2].push_back(IV);
        #1;
        check("lat0_same_cycle_valid", {31'b0, av0}, 32'd1);
        check("lat0_same_cycle_data", ar0, IV);
        tick;
        idle;

        for (int i = 0; i < 16; i++) model[i] = IV;
        model[5] = 32'hDE22BE44;
        model[7] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) issue(1, 8'(i), model[i], 0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
        repeat (2) tick;

        // Reset in the middle of the sweep, with writes pending during init.
        rst = 1'b1; tick; rst = 1'b0;
        repeat (5) tick;
        check("midsweep_init_done", {31'b0, done1}, 32'd0);
        rst = 1'b1; tick; rst = 1'b0;
        a_en = 1'b1; a_addr = 8'd2;
        b_en = 1'b1; b_wen = 1'b1; b_be = 4'hF; b_addr = 8'd2; b_wdata = 32'h12345678;
        wait_init(n1, n0);
        idle;
        check("restart_clocks_lat1", n1, 32'd16);
        check("restart_clocks_lat0", n0, 32'd16);
        issue(1, 8'd2, IV, 0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
        issue(1, 8'd5, IV, 1, 0, 4'h0, 8'd7, 32'h0, IV);
        repeat (3) tick;

        for (int s = 0; s < 4; s++) check({"drained_", qn[s]}, q[s].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end
endmodule
